// File: rtl/key_event_queue_if.sv
// key_event_queue_if: byte-stream input, event-FIFO output and status bundle for key_event_queue
//   master: drives key_en/key_data (PS/2 bytes), rd_en (pop), clr_ovf; observes the event/status outputs
//   slave : the queue itself
interface key_event_queue_if #(
    parameter int DEPTH     = 8,
    parameter int NUM_TRACK = 4
);
    logic                     key_en;
    logic [7:0]               key_data;
    logic                     rd_en;
    logic                     clr_ovf;
    logic                     ev_valid;
    logic [7:0]               ev_keycode;
    logic                     ev_ext;
    logic                     ev_make;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [NUM_TRACK-1:0]     held;
    modport master (
        output key_en, key_data, rd_en, clr_ovf,
        input  ev_valid, ev_keycode, ev_ext, ev_make, count, overflow, held
    );
    modport slave (
        input  key_en, key_data, rd_en, clr_ovf,
        output ev_valid, ev_keycode, ev_ext, ev_make, count, overflow, held
    );
endinterface

// File: rtl/key_event_queue.sv
// key_event_queue: PS/2 scancode decoder feeding a FWFT event FIFO with a held-key bitmap
//   clk, reset : clock, synchronous active-high reset
//   bus.key_en/key_data : incoming scancode byte strobe
//   bus.rd_en/clr_ovf   : pop head event, clear sticky overflow
//   bus.ev_*            : head event {ext, make, code}, zero when empty
//   bus.count/overflow/held : occupancy, lost-event flag, tracked-key press map
module key_event_queue #(
    parameter int                     DEPTH         = 8,
    parameter int                     NUM_TRACK     = 4,
    parameter logic [NUM_TRACK*9-1:0] TRACK_CODES   = {9'h175, 9'h172, 9'h16B, 9'h174},
    parameter bit                     FILTER_REPEAT = 1'b1
) (
    input logic                clk,
    input logic                reset,
    key_event_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_skip, w_skip_nxt;
    logic [9:0]             r_mem [DEPTH];
    logic [AW-1:0]          r_rd, r_wr;
    logic [CW-1:0]          r_count;
    logic                   r_ovf;
    logic [NUM_TRACK-1:0]   r_held;
    logic                   w_ev_gen, w_ev_ext, w_ev_make;
    logic [NUM_TRACK-1:0]   w_match;
    logic                   w_filt, w_pop, w_push_req, w_push, w_lost;
    logic [9:0]             w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_ev_gen    = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_make   = 1'b1;
        if (bus.key_en) begin
            case (r_state)
                IDLE: begin
                    if (bus.key_data == 8'hE0) w_state_nxt = EXT;
                    else if (bus.key_data == 8'hF0) w_state_nxt = BRK;
                    else if (bus.key_data == 8'hE1) begin
                        w_state_nxt = PAUSE;
                        w_skip_nxt  = 3'd7;
                    end
                    // AA (self-test pass) and FA (ack) are controller chatter, not keys
                    else w_ev_gen = (bus.key_data != 8'hAA) && (bus.key_data != 8'hFA);
                end
                EXT: begin
                    if (bus.key_data == 8'hF0) w_state_nxt = EXT_BRK;
                    else if (bus.key_data != 8'hE0) begin
                        w_ev_gen    = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_ev_gen    = 1'b1;
                    w_ev_make   = 1'b0;
                    w_state_nxt = IDLE;
                end
                EXT_BRK: begin
                    w_ev_gen    = 1'b1;
                    w_ev_ext    = 1'b1;
                    w_ev_make   = 1'b0;
                    w_state_nxt = IDLE;
                end
                PAUSE: begin
                    w_skip_nxt  = r_skip - 3'd1;
                    w_state_nxt = (r_skip == 3'd1) ? IDLE : PAUSE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_TRACK; i++) begin : g_match
        assign w_match[i] = w_ev_gen && ({w_ev_ext, bus.key_data} == TRACK_CODES[9*i +: 9]);
    end

    // A repeated make of an already-held tracked key is typematic noise
    assign w_filt     = FILTER_REPEAT && w_ev_make && |(w_match & r_held);
    assign w_pop      = bus.rd_en && (r_count != '0);
    assign w_push_req = w_ev_gen && !w_filt;
    assign w_push     = w_push_req && ((r_count < CW'(DEPTH)) || w_pop);
    assign w_lost     = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_skip  <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_ovf   <= w_lost ? 1'b1 : (bus.clr_ovf ? 1'b0 : r_ovf);
            for (int k = 0; k < NUM_TRACK; k++)
                if (w_match[k]) r_held[k] <= w_ev_make;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_ev_ext, w_ev_make, bus.key_data};
    end

    assign w_head         = r_mem[r_rd];
    assign bus.ev_valid   = (r_count != '0);
    assign bus.ev_keycode = bus.ev_valid ? w_head[7:0] : 8'h00;
    assign bus.ev_make    = bus.ev_valid ? w_head[8] : 1'b0;
    assign bus.ev_ext     = bus.ev_valid ? w_head[9] : 1'b0;
    assign bus.count      = r_count;
    assign bus.overflow   = r_ovf;
    assign bus.held       = r_held;
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: scoreboard bench driving a filtering and a non-filtering queue with one byte stream
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_en = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;

    key_event_queue_if #(.DEPTH(8), .NUM_TRACK(4)) b0();
    key_event_queue_if #(.DEPTH(8), .NUM_TRACK(4)) b1();

    assign b0.key_en = key_en;
    assign b0.key_data = key_data;
    assign b0.rd_en = rd_en;
    assign b0.clr_ovf = clr_ovf;
    assign b1.key_en = key_en;
    assign b1.key_data = key_data;
    assign b1.rd_en = rd_en;
    assign b1.clr_ovf = clr_ovf;

    // Entry 0 = up arrow (E0 75) so held[0] tracks "up"
    localparam logic [35:0] TC = {9'h174, 9'h16B, 9'h172, 9'h175};

    key_event_queue #(.DEPTH(8), .NUM_TRACK(4), .TRACK_CODES(TC), .FILTER_REPEAT(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    key_event_queue #(.DEPTH(8), .NUM_TRACK(4), .TRACK_CODES(TC), .FILTER_REPEAT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && rd_en && b0.ev_valid) begin
            if (q0.size() == 0) chk("pop0 unexpected", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, -1);
            else chk("pop0", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, q0.pop_front());
        end
        if (!reset && rd_en && b1.ev_valid) begin
            if (q1.size() == 0) chk("pop1 unexpected", {b1.ev_ext, b1.ev_make, b1.ev_keycode}, -1);
            else chk("pop1", {b1.ev_ext, b1.ev_make, b1.ev_keycode}, q1.pop_front());
        end
    end

    task automatic send(input logic [7:0] b);
        key_en = 1'b1;
        key_data = b;
        @(posedge clk);
        #1;
        key_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_ev(input logic e, input logic m, input logic [7:0] c, input bit to0, input bit to1);
        if (to0) q0.push_back({e, m, c});
        if (to1) q1.push_back({e, m, c});
    endtask

    task automatic drain(output int pops0);
        int n;
        n = 0;
        pops0 = 0;
        rd_en = 1'b1;
        while ((b0.ev_valid || b1.ev_valid) && n < 40) begin
            if (b0.ev_valid) pops0++;
            @(posedge clk);
            #1;
            n++;
        end
        rd_en = 1'b0;
        chk("drain timeout", n >= 40, 0);
        chk("q0 leftover", q0.size(), 0);
        chk("q1 leftover", q1.size(), 0);
        chk("empty keycode", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, 0);
    endtask

    initial begin
        int p;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset count", b0.count, 0);
        chk("reset valid", b0.ev_valid, 0);
        chk("reset ovf", b0.overflow, 0);
        chk("reset held", b0.held, 0);
        chk("reset keycode", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, 0);

        // Basic make / extended make / break ordering
        send(8'h1D);
        expect_ev(0, 1, 8'h1D, 1, 1);
        send(8'hE0); send(8'h75);
        expect_ev(1, 1, 8'h75, 1, 1);
        send(8'hF0); send(8'h1D);
        expect_ev(0, 0, 8'h1D, 1, 1);
        chk("t1 count", b0.count, 3);
        chk("t1 held", b0.held, 4'b0001);
        chk("t1 head", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, 10'h11D);
        drain(p);

        // Typematic repeat: filtered on dut0, passed on dut1
        do_reset();
        send(8'hE0); send(8'h75);
        expect_ev(1, 1, 8'h75, 1, 1);
        chk("t2 held up", b0.held, 4'b0001);
        send(8'hE0); send(8'h75);
        expect_ev(1, 1, 8'h75, 0, 1);
        send(8'hE0); send(8'h75);
        expect_ev(1, 1, 8'h75, 0, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev(1, 0, 8'h75, 1, 1);
        chk("t2 count filt", b0.count, 2);
        chk("t2 count nofilt", b1.count, 4);
        chk("t2 held rel", b0.held, 0);
        chk("t2 held rel nf", b1.held, 0);
        drain(p);

        // Overflow: 10 pushes into 8 entries
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(8'h10 + 8'(i));
            if (i < 8) expect_ev(0, 1, 8'h10 + 8'(i), 1, 1);
        end
        chk("t3 count", b0.count, 8);
        chk("t3 ovf", b0.overflow, 1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        chk("t3 ovf clr", b0.overflow, 0);
        drain(p);
        chk("t3 pops", p, 8);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(8'h20 + 8'(i));
            expect_ev(0, 1, 8'h20 + 8'(i), 1, 1);
        end
        expect_ev(0, 1, 8'h28, 1, 1);
        rd_en = 1'b1;
        send(8'h28);
        rd_en = 1'b0;
        chk("t4 count", b0.count, 8);
        chk("t4 ovf", b0.overflow, 0);
        chk("t4 head", b0.ev_keycode, 8'h21);
        drain(p);
        chk("t4 pops", p, 8);

        // Pause sequence skipped, AA/FA ignored
        do_reset();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        expect_ev(0, 1, 8'h1C, 1, 1);
        send(8'hAA); send(8'hFA);
        chk("t5 count", b0.count, 1);
        drain(p);

        // Reset mid-prefix discards the E0
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h72);
        expect_ev(0, 1, 8'h72, 1, 1);
        chk("t6 count", b0.count, 1);
        chk("t6 held", b0.held, 0);
        chk("t6 head", {b0.ev_ext, b0.ev_make, b0.ev_keycode}, 10'h172);
        drain(p);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
